// File: rtl/ladybird_config.sv
// Shared definitions for the ladybird UART loader: opcodes, status bytes and FSM states.
package ladybird_config;

    localparam int         XLEN_DEF     = 32;
    localparam logic [7:0] OP_WRITE     = 8'h57;
    localparam logic [7:0] OP_READ      = 8'h52;
    localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_WREQ,
        ST_RREQ,
        ST_RWAIT,
        ST_RDATA,
        ST_STAT
    } loader_state_t;

    // Bus addresses are always word aligned; the host's low address bits are ignored.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ladybird_loader_shifter.sv
// Little-endian 4-byte shift register: bytes enter at the top so the first byte ends up in
// bits [7:0]; shifting also pops the low byte for transmit. count_o tracks bytes since load/clear.
module ladybird_loader_shifter
    import ladybird_config::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                clr,
    input  logic                load,
    input  logic [XLEN_DEF-1:0] load_word,
    input  logic                shift,
    input  logic [7:0]          shift_byte,
    output logic [XLEN_DEF-1:0] word_o,
    output logic [2:0]          count_o
);

    logic [XLEN_DEF-1:0] word_q, word_d;
    logic [2:0]          count_q, count_d;

    // Next word/count: load wins over shift, shift wins over clear.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (load) begin
            word_d  = load_word;
            count_d = 3'd0;
        end else if (shift) begin
            word_d  = {shift_byte, word_q[XLEN_DEF-1:8]};
            count_d = count_q + 3'd1;
        end else if (clr) begin
            count_d = 3'd0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            word_q  <= '0;
            count_q <= 3'd0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign word_o  = word_q;
    assign count_o = count_q;

endmodule

// File: rtl/ladybird_uart_loader.sv
// UART-driven bus initiator: parses OP/ADDR/LEN/DATA frames from the RX byte stream, issues
// word reads/writes on the bus, and returns read data plus an ACK/NAK status byte on TX.
module ladybird_uart_loader
    import ladybird_config::*;
#(
    parameter int         XLEN     = XLEN_DEF,
    parameter int         TIMEOUT  = 1023,
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [7:0] NAK_BYTE = NAK_BYTE_DEF
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            core_hold,
    output logic            err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    loader_state_t state_q, state_d;
    logic          is_write_q, is_write_d;
    logic          len_hi_q, len_hi_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    status_q, status_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          core_hold_q, core_hold_d;
    logic          err_q, err_d;

    logic          rxw_clr, rxw_shift, addr_clr, addr_shift, addr_load, txw_load, txw_shift;
    logic [31:0]   rxw_word, addr_word, txw_word, addr_next;
    logic [2:0]    rxw_cnt, addr_cnt, txw_cnt;
    logic [7:0]    tx_byte;
    logic [23:0]   txw_unused;
    logic          rx_fire, tx_fire, tmo_hit;

    ladybird_loader_shifter u_rxw (
        .clk(clk), .nrst(nrst), .clr(rxw_clr), .load(1'b0), .load_word(32'h0),
        .shift(rxw_shift), .shift_byte(rx_data), .word_o(rxw_word), .count_o(rxw_cnt)
    );

    ladybird_loader_shifter u_addr (
        .clk(clk), .nrst(nrst), .clr(addr_clr), .load(addr_load), .load_word(addr_next),
        .shift(addr_shift), .shift_byte(rx_data), .word_o(addr_word), .count_o(addr_cnt)
    );

    ladybird_loader_shifter u_txw (
        .clk(clk), .nrst(nrst), .clr(1'b0), .load(txw_load), .load_word(bus_rdata),
        .shift(txw_shift), .shift_byte(8'h00), .word_o(txw_word), .count_o(txw_cnt)
    );

    assign {txw_unused, tx_byte} = txw_word;
    assign addr_next = word_align(addr_word) + 32'd4;
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

    // Handshake-facing outputs decode straight from the registered state.
    assign rx_ready  = nrst & (state_q inside {ST_IDLE, ST_ADDR, ST_LEN, ST_WDATA});
    assign tx_valid  = state_q inside {ST_RDATA, ST_STAT};
    assign tx_data   = (state_q == ST_RDATA) ? tx_byte :
                       (state_q == ST_STAT)  ? status_q : 8'h00;
    assign bus_req   = state_q inside {ST_WREQ, ST_RREQ};
    assign bus_we    = (state_q == ST_WREQ);
    assign bus_wstrb = bus_we ? 4'hF : 4'h0;
    assign bus_addr  = word_align(addr_word);
    assign bus_wdata = rxw_word;
    assign core_hold = core_hold_q;
    assign err       = err_q;
    assign rx_fire   = rx_valid & rx_ready;
    assign tx_fire   = tx_valid & tx_ready;

    // Frame parser / bus sequencer next-state logic.
    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        len_hi_d    = len_hi_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        tmo_d       = '0;
        core_hold_d = core_hold_q;
        err_d       = err_q;
        rxw_clr     = 1'b0;
        rxw_shift   = 1'b0;
        addr_clr    = 1'b0;
        addr_shift  = 1'b0;
        addr_load   = 1'b0;
        txw_load    = 1'b0;
        txw_shift   = 1'b0;
        case (state_q)
            ST_IDLE: if (rx_fire) begin
                core_hold_d = 1'b1;
                addr_clr    = 1'b1;
                if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                    is_write_d = (rx_data == OP_WRITE);
                    state_d    = ST_ADDR;
                end else begin
                    status_d = NAK_BYTE;
                    state_d  = ST_STAT;
                end
            end
            ST_ADDR: if (rx_fire) begin
                addr_shift = 1'b1;
                if (addr_cnt == 3'd3) begin
                    len_hi_d = 1'b0;
                    state_d  = ST_LEN;
                end
            end
            ST_LEN: if (rx_fire) begin
                cnt_d    = {rx_data, cnt_q[15:8]};
                len_hi_d = 1'b1;
                if (len_hi_q) begin
                    if ({rx_data, cnt_q[15:8]} == 16'd0) begin
                        status_d = ACK_BYTE;
                        state_d  = ST_STAT;
                    end else if (is_write_q) begin
                        rxw_clr = 1'b1;
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_RREQ;
                    end
                end
            end
            ST_WDATA: if (rx_fire) begin
                rxw_shift = 1'b1;
                if (rxw_cnt == 3'd3) state_d = ST_WREQ;
            end
            ST_WREQ: begin
                if (bus_gnt) begin
                    addr_load = 1'b1;
                    cnt_d     = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        status_d = ACK_BYTE;
                        state_d  = ST_STAT;
                    end else begin
                        rxw_clr = 1'b1;
                        state_d = ST_WDATA;
                    end
                end else if (tmo_hit) begin
                    err_d    = 1'b1;
                    status_d = NAK_BYTE;
                    state_d  = ST_STAT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RREQ: begin
                if (bus_gnt) begin
                    txw_load = bus_rvalid;
                    state_d  = bus_rvalid ? ST_RDATA : ST_RWAIT;
                end else if (tmo_hit) begin
                    err_d    = 1'b1;
                    status_d = NAK_BYTE;
                    state_d  = ST_STAT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RWAIT: begin
                if (bus_rvalid) begin
                    txw_load = 1'b1;
                    state_d  = ST_RDATA;
                end else if (tmo_hit) begin
                    err_d    = 1'b1;
                    status_d = NAK_BYTE;
                    state_d  = ST_STAT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RDATA: if (tx_fire) begin
                txw_shift = 1'b1;
                if (txw_cnt == 3'd3) begin
                    addr_load = 1'b1;
                    cnt_d     = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        status_d = ACK_BYTE;
                        state_d  = ST_STAT;
                    end else begin
                        state_d = ST_RREQ;
                    end
                end
            end
            ST_STAT: if (tx_fire) begin
                core_hold_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            len_hi_q    <= 1'b0;
            cnt_q       <= 16'd0;
            status_q    <= 8'h00;
            tmo_q       <= '0;
            core_hold_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            len_hi_q    <= len_hi_d;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
            tmo_q       <= tmo_d;
            core_hold_q <= core_hold_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ladybird_uart_loader.sv
// Directed bench for ladybird_uart_loader with a scoreboard of expected bus and TX transactions.
module tb_ladybird_uart_loader;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid, core_hold, err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        gnt_en;

    int          checks = 0;
    int          errors = 0;
    int          req_cycles = 0;
    int          rd_wait = 0;
    int          rdelay = 1;
    logic [31:0] rd_val = 32'h0;
    logic        rv_prev = 1'b0;
    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];

    always #5 clk = ~clk;

    assign bus_gnt = gnt_en & bus_req;

    ladybird_uart_loader dut (
        .clk(clk), .nrst(nrst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .core_hold(core_hold), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_t e;
        e.we = we; e.addr = a; e.wdata = d;
        exp_bus.push_back(e);
    endtask

    // One clock: sample at the falling edge, score handshakes, model the bus target.
    task automatic tick(output bit rx_fired);
        bus_t       e;
        logic [7:0] t;
        @(negedge clk);
        rx_fired = rx_valid && rx_ready;
        if (bus_req) req_cycles++;
        if (rv_prev) chk("rdata_latency", {31'b0, tx_valid}, 32'd1);
        if (bus_req && bus_gnt) begin
            if (exp_bus.size() == 0) begin
                chk("bus_extra", exp_bus.size(), 32'd1);
            end else begin
                e = exp_bus.pop_front();
                chk("bus_we", {31'b0, bus_we}, {31'b0, e.we});
                chk("bus_addr", bus_addr, e.addr);
                chk("bus_wstrb", {28'b0, bus_wstrb}, e.we ? 32'hF : 32'h0);
                if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
                $display("bus we=%0b addr=%08h wdata=%08h", bus_we, bus_addr, bus_wdata);
            end
        end
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                chk("tx_extra", exp_tx.size(), 32'd1);
            end else begin
                t = exp_tx.pop_front();
                chk("tx_data", {24'b0, tx_data}, {24'b0, t});
                $display("tx byte=%02h", tx_data);
            end
        end
        bus_rvalid = 1'b0;
        if (rd_wait != 0) begin
            rd_wait--;
            if (rd_wait == 0) begin
                bus_rvalid = 1'b1;
                bus_rdata  = rd_val;
            end
        end
        if (bus_req && bus_gnt && !bus_we) rd_wait = rdelay;
        rv_prev = bus_rvalid;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit f;
        f = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 2000 && !f; n++) tick(f);
        rx_valid = 1'b0;
        chk("rx_accept", {31'b0, f}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [31:0] a, input logic [15:0] len);
        send_byte(op);
        chk("core_hold_rise", {31'b0, core_hold}, 32'd1);
        send_word(a);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic wait_idle(input int budget);
        bit f;
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < budget) begin
            tick(f);
            n++;
        end
        chk("drain", exp_tx.size() + exp_bus.size(), 32'd0);
    endtask

    initial begin
        bit f;
        int unstable;
        nrst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        gnt_en = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) tick(f);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_core_hold", {31'b0, core_hold}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("rst_wstrb", {28'b0, bus_wstrb}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        nrst = 1'b1;
        tick(f);
        chk("idle_rx_ready", {31'b0, rx_ready}, 32'd1);

        // 1: two-word write with immediate grant
        push_bus(1'b1, 32'h9000_0000, 32'hDEAD_BEEF);
        push_bus(1'b1, 32'h9000_0004, 32'h1234_5678);
        exp_tx.push_back(8'h06);
        send_hdr(8'h57, 32'h9000_0000, 16'd2);
        send_word(32'hDEAD_BEEF);
        chk("wreq_latency", {31'b0, bus_req}, 32'd1);
        send_word(32'h1234_5678);
        wait_idle(200);
        chk("core_hold_fall", {31'b0, core_hold}, 32'd0);
        chk("err_clean", {31'b0, err}, 32'd0);

        // 2: one-word read, rvalid three cycles after grant
        rdelay = 3; rd_val = 32'hCAFE_F00D;
        push_bus(1'b0, 32'h9000_0004, 32'h0);
        exp_tx.push_back(8'h0D); exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'hFE); exp_tx.push_back(8'hCA);
        exp_tx.push_back(8'h06);
        send_hdr(8'h52, 32'h9000_0004, 16'd1);
        wait_idle(200);

        // 3: unknown opcode, then zero-length read
        req_cycles = 0;
        exp_tx.push_back(8'h15);
        send_byte(8'h58);
        chk("nak_immediate", {31'b0, tx_valid}, 32'd1);
        wait_idle(50);
        exp_tx.push_back(8'h06);
        send_hdr(8'h52, 32'h0000_1000, 16'd0);
        wait_idle(50);
        chk("no_bus_req", req_cycles, 32'd0);

        // 4: read whose grant never arrives
        gnt_en = 1'b0; req_cycles = 0;
        exp_tx.push_back(8'h15);
        send_hdr(8'h52, 32'h0000_2000, 16'd1);
        wait_idle(1500);
        chk("timeout_req_cycles", req_cycles, 32'd1023);
        chk("timeout_err", {31'b0, err}, 32'd1);
        gnt_en = 1'b1;

        // 5: wrapping write with a stalled transmitter
        tx_ready = 1'b0;
        push_bus(1'b1, 32'hFFFF_FFFC, 32'h4433_2211);
        push_bus(1'b1, 32'h0000_0000, 32'h8877_6655);
        exp_tx.push_back(8'h06);
        send_hdr(8'h57, 32'hFFFF_FFFF, 16'd2);
        send_word(32'h4433_2211);
        send_word(32'h8877_6655);
        for (int n = 0; n < 50 && !tx_valid; n++) tick(f);
        unstable = 0;
        for (int n = 0; n < 20; n++) begin
            tick(f);
            if (!tx_valid || tx_data !== 8'h06) unstable++;
        end
        chk("tx_stable", unstable, 32'd0);
        chk("err_sticky", {31'b0, err}, 32'd1);
        tx_ready = 1'b1;
        wait_idle(50);

        // reset while a write request is pending
        gnt_en = 1'b0;
        send_hdr(8'h57, 32'h0000_3000, 16'd1);
        send_word(32'hA5A5_A5A5);
        chk("req_before_reset", {31'b0, bus_req}, 32'd1);
        nrst = 1'b0;
        tick(f);
        chk("reset_bus_req", {31'b0, bus_req}, 32'd0);
        chk("reset_core_hold", {31'b0, core_hold}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
        nrst = 1'b1; gnt_en = 1'b1;
        tick(f);
        exp_tx.push_back(8'h15);
        send_byte(8'h00);
        wait_idle(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
